// File: rtl/ch77_alarm_logger.sv
// ch77_alarm_logger: snoops channel-77 monitor reads, logs newly raised alarms with timestamps
// into a FWFT FIFO, keeps per-alarm saturating counters and requests a channel clear.
module ch77_alarm_logger #(
   parameter int DEPTH = 8,
   parameter int TSW   = 16,
   parameter int CW    = 8
) (
   input  logic             SIM_CLK,
   input  logic             SIM_RST,
   input  logic             MT01,
   input  logic             MT05,
   input  logic             MRCH,
   input  logic [5:0]       MWL,
   input  logic [8:0]       MDT,
   input  logic             TS_TICK,
   input  logic             POP,
   input  logic             OVF_CLR,
   input  logic [3:0]       CNT_SEL,
   output logic             EV_VALID,
   output logic [9+TSW-1:0] EV_DATA,
   output logic             EV_OVF,
   output logic [CW-1:0]    CNT_VAL,
   output logic             CLR_REQ
);
   localparam int AW = $clog2(DEPTH);
   localparam int EW = 9 + TSW;
   typedef enum logic [1:0] {IDLE, ARMED, CAPTURE, COMMIT} state_t;
   state_t          r_state;
   logic            r_mt01, r_mt05, r_ovf, r_clr;
   logic [8:0]      r_snap, r_prev;
   logic [TSW-1:0]  r_ts;
   logic [EW-1:0]   r_mem [DEPTH];
   logic [EW-1:0]   r_last;
   logic [AW-1:0]   r_rd, r_wr;
   logic [AW:0]     r_cnt;
   logic [CW-1:0]   r_ctr [9];
   logic            w_rise01, w_rise05, w_ch77, w_push, w_pop, w_full, w_wr;
   logic [8:0]      w_new;
   assign w_rise01 = MT01 & ~r_mt01;
   assign w_rise05 = MT05 & ~r_mt05;
   assign w_ch77   = MRCH && (MWL == 6'o77);
   assign w_new    = r_snap & ~r_prev;
   assign w_push   = (r_state == COMMIT) && (w_new != 9'd0);
   assign w_pop    = POP && (r_cnt != '0);
   assign w_full   = r_cnt == (AW+1)'(DEPTH);
   // a same-cycle pop frees the slot, so a push into a full FIFO still lands
   assign w_wr     = w_push && (!w_full || w_pop);
   assign EV_VALID = r_cnt != '0;
   assign EV_DATA  = EV_VALID ? r_mem[r_rd] : r_last;
   assign EV_OVF   = r_ovf;
   assign CLR_REQ  = r_clr;
   always_ff @(posedge SIM_CLK or negedge SIM_RST) begin
      if (!SIM_RST) begin
         r_state <= IDLE;
         r_mt01  <= 1'b0;
         r_mt05  <= 1'b0;
         r_snap  <= '0;
         r_prev  <= '0;
      end else begin
         r_mt01 <= MT01;
         r_mt05 <= MT05;
         case (r_state)
            IDLE:    if (w_rise01 && w_ch77) r_state <= ARMED;
            ARMED:   if (!MRCH) r_state <= IDLE;
                     else if (w_rise05) begin
                        r_state <= CAPTURE;
                        r_snap  <= MDT;
                     end else if (w_rise01 && !w_ch77) r_state <= IDLE;
            CAPTURE: r_state <= COMMIT;
            default: begin
               r_state <= IDLE;
               r_prev  <= r_snap;
            end
         endcase
      end
   end
   always_ff @(posedge SIM_CLK or negedge SIM_RST) begin
      if (!SIM_RST) begin
         r_ts   <= '0;
         r_clr  <= 1'b0;
         r_ovf  <= 1'b0;
         r_rd   <= '0;
         r_wr   <= '0;
         r_cnt  <= '0;
         r_last <= '0;
         for (int i = 0; i < 9; i++) r_ctr[i] <= '0;
      end else begin
         r_ts  <= r_ts + TSW'(TS_TICK);
         r_clr <= w_push;
         r_ovf <= (w_push && w_full && !w_pop) || (r_ovf && !OVF_CLR);
         r_cnt <= r_cnt + (AW+1)'(w_wr) - (AW+1)'(w_pop);
         if (w_wr) r_wr <= r_wr + AW'(1);
         if (w_pop) r_rd <= r_rd + AW'(1);
         if (EV_VALID) r_last <= r_mem[r_rd];
         for (int i = 0; i < 9; i++)
            if (w_push && w_new[i] && (r_ctr[i] != {CW{1'b1}})) r_ctr[i] <= r_ctr[i] + CW'(1);
      end
   end
   always_ff @(posedge SIM_CLK) begin
      if (w_wr) r_mem[r_wr] <= {r_ts, w_new};
   end
   always_comb begin
      CNT_VAL = '0;
      for (int i = 0; i < 9; i++)
         if (CNT_SEL == 4'(i)) CNT_VAL = r_ctr[i];
   end
endmodule

// File: tb/tb_ch77_alarm_logger.sv
// tb_ch77_alarm_logger: randomized scoreboard bench; a queue-based model of the event log
// is filled by the stimulus and drained by an independent monitor on each observed pop.
`timescale 1ns/1ps
module tb_ch77_alarm_logger;
   localparam int DEPTH = 8;
   localparam int TSW   = 16;
   localparam int CW    = 8;
   logic            SIM_CLK = 0, SIM_RST = 0, MT01 = 0, MT05 = 0, MRCH = 0;
   logic [5:0]      MWL = 0;
   logic [8:0]      MDT = 0;
   logic            TS_TICK = 0, POP = 0, OVF_CLR = 0;
   logic [3:0]      CNT_SEL = 0;
   logic            EV_VALID, EV_OVF, CLR_REQ;
   logic [9+TSW-1:0] EV_DATA;
   logic [CW-1:0]   CNT_VAL;
   ch77_alarm_logger #(.DEPTH(DEPTH), .TSW(TSW), .CW(CW)) dut (
      .SIM_CLK(SIM_CLK), .SIM_RST(SIM_RST), .MT01(MT01), .MT05(MT05), .MRCH(MRCH),
      .MWL(MWL), .MDT(MDT), .TS_TICK(TS_TICK), .POP(POP), .OVF_CLR(OVF_CLR),
      .CNT_SEL(CNT_SEL), .EV_VALID(EV_VALID), .EV_DATA(EV_DATA), .EV_OVF(EV_OVF),
      .CNT_VAL(CNT_VAL), .CLR_REQ(CLR_REQ)
   );
   always #5 SIM_CLK = ~SIM_CLK;
   int checks = 0, failures = 0;
   logic [24:0] exp_q[$];
   int exp_clr = 0, clr_seen = 0;
   logic [8:0] m_prev = 0;
   int mcnt[9];
   bit m_ovf = 0, ts_rand = 0;
   logic [TSW-1:0] m_ts;
   // timestamp reference: number of TS_TICK-high cycles since reset, modulo 2^TSW
   always @(posedge SIM_CLK or negedge SIM_RST)
      if (!SIM_RST) m_ts <= '0;
      else m_ts <= m_ts + TSW'(TS_TICK);
   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%0h required=%0h t=%0t", name, act, exp, $time);
      end
   endtask
   initial forever begin
      @(posedge SIM_CLK); #1;
      if (ts_rand) TS_TICK = 1'($urandom_range(0, 1));
   end
   always @(negedge SIM_CLK) if (SIM_RST) begin
      if (CLR_REQ) clr_seen++;
      if (POP) begin
         if (exp_q.size() != 0) begin
            chk("valid_on_pop", 32'(EV_VALID), 32'd1);
            chk("ev_data", 32'(EV_DATA), 32'(exp_q.pop_front()));
         end else chk("valid_when_empty", 32'(EV_VALID), 32'd0);
      end
   end
   task automatic step();
      @(posedge SIM_CLK); #1;
   endtask
   task automatic txn(input logic [5:0] ch, input logic [8:0] mdt, input bit drop,
                      input bit pop_c, input bit chk_lat);
      logic [8:0] nw;
      MRCH = 1; MWL = ch; MDT = mdt; MT01 = 1; step();
      MT01 = 0; step();
      if (drop) begin MRCH = 0; step(); end
      MT05 = 1; step();
      MT05 = 0; MRCH = 0; step();
      if (chk_lat) chk("valid_before_latency", 32'(EV_VALID), 32'd0);
      if (ch == 6'o77 && !drop) begin
         nw = mdt & ~m_prev;
         m_prev = mdt;
         if (nw != 0) begin
            exp_clr++;
            for (int i = 0; i < 9; i++) if (nw[i] && mcnt[i] < 255) mcnt[i]++;
            if (pop_c) POP = 1;
            if (exp_q.size() == DEPTH && !pop_c) m_ovf = 1;
            else exp_q.push_back({m_ts, nw});
         end
      end
      step();
      POP = 0;
      if (chk_lat) begin
         chk("valid_latency", 32'(EV_VALID), 32'd1);
         chk("clr_req_latency", 32'(CLR_REQ), 32'd1);
      end
      step();
   endtask
   task automatic pop_all();
      int g = 0;
      while (exp_q.size() != 0 && g < 4 * DEPTH) begin
         POP = 1; step(); POP = 0; g++;
      end
      chk("drained", 32'(exp_q.size()), 32'd0);
   endtask
   task automatic ovf_clr();
      OVF_CLR = 1; step(); OVF_CLR = 0; m_ovf = 0;
   endtask
   task automatic check_model();
      chk("ev_ovf", 32'(EV_OVF), 32'(m_ovf));
      chk("ev_valid", 32'(EV_VALID), 32'(exp_q.size() != 0));
      chk("clr_count", clr_seen, exp_clr);
      for (int i = 0; i < 9; i++) begin
         CNT_SEL = 4'(i); #1;
         chk($sformatf("cnt%0d", i), 32'(CNT_VAL), mcnt[i]);
      end
      CNT_SEL = 4'd12; #1;
      chk("cnt_sel_oob", 32'(CNT_VAL), 32'd0);
      CNT_SEL = 0;
      step();
   endtask
   task automatic reset_model();
      exp_q.delete(); m_prev = 0; m_ovf = 0;
      for (int i = 0; i < 9; i++) mcnt[i] = 0;
   endtask
   task automatic chk_reset_outputs();
      CNT_SEL = 0; #1;
      chk("rst_valid", 32'(EV_VALID), 32'd0);
      chk("rst_data", 32'(EV_DATA), 32'd0);
      chk("rst_ovf", 32'(EV_OVF), 32'd0);
      chk("rst_clr", 32'(CLR_REQ), 32'd0);
      chk("rst_cnt", 32'(CNT_VAL), 32'd0);
   endtask
   initial begin
      logic [5:0] ch;
      logic [8:0] md;
      reset_model();
      SIM_RST = 0; #2;
      chk_reset_outputs();
      step(); SIM_RST = 1; step();
      ts_rand = 1;
      txn(6'o77, 9'h001, 0, 0, 1);
      chk("first_head", 32'(EV_DATA), 32'(exp_q[0]));
      check_model();
      pop_all();
      txn(6'o77, 9'h001, 0, 0, 0);
      check_model();
      txn(6'o77, 9'h000, 0, 0, 0);
      txn(6'o77, 9'h001, 0, 0, 0);
      check_model();
      pop_all();
      txn(6'o76, 9'h1FF, 0, 0, 0);
      txn(6'o77, 9'h1FF, 1, 0, 0);
      check_model();
      for (int k = 0; k <= DEPTH; k++) begin
         txn(6'o77, 9'(1 << (k % 9)), 0, 0, 0);
         txn(6'o77, 9'h000, 0, 0, 0);
      end
      check_model();
      ovf_clr();
      check_model();
      txn(6'o77, 9'h002, 0, 1, 0);
      check_model();
      pop_all();
      for (int k = 0; k < 260; k++) begin
         txn(6'o77, 9'h100, 0, 0, 0);
         txn(6'o77, 9'h000, 0, 0, 0);
      end
      check_model();
      pop_all();
      ovf_clr();
      for (int k = 0; k < 200; k++) begin
         ch = ($urandom_range(0, 3) == 0) ? 6'($urandom) : 6'o77;
         md = ($urandom_range(0, 3) == 0) ? 9'h000 : 9'($urandom);
         txn(ch, md, $urandom_range(0, 5) == 0, 0, 0);
         if ($urandom_range(0, 2) == 0)
            repeat ($urandom_range(1, 4)) if (exp_q.size() != 0) begin
               POP = 1; step(); POP = 0;
            end
         if (k % 25 == 24) check_model();
      end
      pop_all();
      check_model();
      ts_rand = 0; TS_TICK = 0;
      SIM_RST = 0; reset_model(); step(); SIM_RST = 1;
      TS_TICK = 1;
      repeat (65539) step();
      TS_TICK = 0;
      txn(6'o77, 9'h001, 0, 0, 0);
      chk("ts_wrap", 32'(EV_DATA[24:9]), 32'd3);
      pop_all();
      MRCH = 1; MWL = 6'o77; MDT = 9'h1FF; MT01 = 1; step();
      MT01 = 0; step();
      SIM_RST = 0; reset_model();
      chk_reset_outputs();
      step(); SIM_RST = 1;
      MT05 = 1; step();
      MT05 = 0; MRCH = 0;
      repeat (4) step();
      check_model();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule

// File: doc/ch77_alarm_logger.md
Name: ch77_alarm_logger

Overview:
- Downstream consumer of the channel-77 alarm box: snoops monitor-bus reads of channel 77 and captures the alarm word (MDT01..MDT09).
- Detects newly raised alarms by comparing against the previous capture.
- Queues each new-alarm event with a timestamp in a FIFO and keeps per-alarm saturating counters for the host/test-harness side.
- Requests a channel-77 clear after each logged event.

Parameters:
- DEPTH, 8, event FIFO depth in entries; power of two, 2..64.
- TSW, 16, timestamp counter width in bits.
- CW, 8, per-alarm event counter width in bits.

Ports:
- SIM_CLK  in  1  single clock; all state on rising edge.
- SIM_RST  in  1  reset, asynchronous, active-low.
- MT01  in  1  timing pulse 1 (level, synchronous to SIM_CLK).
- MT05  in  1  timing pulse 5 (level, synchronous to SIM_CLK).
- MRCH  in  1  monitor read-channel strobe.
- MWL  in  6  channel address, MWL01..MWL06; bit0 = MWL01.
- MDT  in  9  alarm data MDT01..MDT09; bit0 = MDT01.
- TS_TICK  in  1  timestamp increment enable.
- POP  in  1  host dequeue request.
- OVF_CLR  in  1  clears the overflow flag.
- CNT_SEL  in  4  counter index 0..8.
- EV_VALID  out  1  FIFO not empty.
- EV_DATA  out  9+TSW  head entry {ts[TSW-1:0], new_alarms[8:0]}.
- EV_OVF  out  1  sticky overflow flag.
- CNT_VAL  out  CW  counter[CNT_SEL]; reads 0 when CNT_SEL > 8.
- CLR_REQ  out  1  one-cycle pulse requesting a channel-77 clear write.

Behaviour:
- Reset (SIM_RST low, async): FSM = IDLE; prev snapshot = 0; FIFO empty; ts = 0; all counters = 0. Outputs: EV_VALID = 0, EV_DATA = 0, EV_OVF = 0, CLR_REQ = 0, CNT_VAL = 0. Reset mid-capture discards the capture with no push.
- Edge detect: MT01 and MT05 are registered once; their rising edges (rise01, rise05) are single-cycle internal events.
- FSM states IDLE, ARMED, CAPTURE, COMMIT.
  - IDLE -> ARMED on rise01 with MRCH = 1 and MWL = 6'o77.
  - ARMED -> CAPTURE on rise05 with MRCH still 1; MDT is latched into snap that cycle.
  - ARMED -> IDLE (abort, no capture) if MRCH drops before rise05, or on rise01 without a channel-77 read.
  - CAPTURE -> COMMIT unconditionally (1 cycle).
  - COMMIT -> IDLE unconditionally.
- COMMIT actions, all in the COMMIT cycle:
  - new = snap & ~prev; prev <= snap. An all-zero snap clears prev, so a re-raised alarm after a clear counts again.
  - If new != 0: push {ts, new}; each counter i with new[i] = 1 increments, saturating at 2^CW-1; CLR_REQ pulses high in the following cycle.
  - If new == 0: no push, no count, no CLR_REQ.
- Latency: COMMIT is 2 cycles after the rise05 cycle; EV_VALID rises in the cycle after COMMIT; CLR_REQ is asserted in that same cycle.
- ts is a free-running TSW-bit counter, incremented on each cycle with TS_TICK = 1; it wraps from all-ones to 0. The pushed ts is the value during the COMMIT cycle.
- FIFO: first-word fall-through; EV_DATA shows the head whenever EV_VALID = 1 and holds its last value when empty.
  - POP with EV_VALID = 1 removes the head; POP while empty is ignored.
  - Push while full: event dropped and EV_OVF set. If POP occurs in the same cycle, the pop frees the slot, the push succeeds, and EV_OVF is not set.
  - Simultaneous push and pop when non-empty and not full: count unchanged.
- EV_OVF is sticky; cleared by OVF_CLR = 1. If OVF_CLR and a new overflow occur in the same cycle, set wins.
- Counters and CNT_VAL: CNT_VAL is combinational from CNT_SEL.

Test Plan:
- Reset then MRCH = 1, MWL = 077, MT01 pulse, MT05 pulse, MDT = 9'h001 -> EV_VALID = 1 three cycles after rise05; EV_DATA = {ts, 9'h001}; counter[0] = 1; one CLR_REQ pulse.
- Same read repeated with MDT = 9'h001 -> no push; counter[0] stays 1. Then a read with MDT = 0, then a read with MDT = 9'h001 -> second event pushed; counter[0] = 2.
- MWL = 076 read, or MRCH dropped between MT01 and MT05, with MDT = 9'h1FF -> no event, FSM returns to IDLE.
- DEPTH+1 distinct new-alarm events with no POP -> DEPTH entries held, EV_OVF = 1. Then OVF_CLR -> EV_OVF = 0. Then push with simultaneous POP while full -> no overflow.
- 260 events on bit 8 (alternating 9'h100 and 0 captures) -> CNT_VAL with CNT_SEL = 8 reads 255; CNT_SEL = 12 reads 0.
- TS_TICK held high for 2^16 + 3 cycles -> ts wraps to 3. Assert SIM_RST during ARMED -> no push, all outputs 0.
